// File: rtl/cpu_memory_responder_pkg.sv
// Shared widths and sequencer state encodings for the CPU memory responder.
// Boot order is ZERO (wipe RAM) -> LOAD (take program bytes) -> RUN (CPU owns RAM).
package cpu_memory_responder_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_ZERO = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // High when the pointer sits on the top word, which ends both ZERO and LOAD.
  function automatic logic ptr_at_last(input logic [ADDR_W_DEF-1:0] ptr);
    return (ptr == {ADDR_W_DEF{1'b1}});
  endfunction

endpackage

// File: rtl/cpu_memory_responder_ram_sp_async_rd.sv
// Single-port RAM: one synchronous write port and an asynchronous read port.
// Read-during-write to the same word returns the old contents until the next cycle.
module ram_sp_async_rd #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage array update; no reset, contents are established by the boot wipe.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_memory_responder.sv
// Memory-side responder for the CPU: RAM plus a boot sequencer that wipes the RAM,
// takes a program byte stream and only then releases the CPU from clear.
module cpu_memory_responder
  import cpu_memory_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] memoryIn,
  output logic [DATA_W-1:0] memoryOut,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_clr,
  output logic              conflict
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_conflict;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  // Write-port ownership: sequencer during boot, CPU in RUN; clr blocks every write.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ptr;
    w_wdata = {DATA_W{1'b0}};
    if (clr) begin
      w_we = 1'b0;
    end else begin
      case (r_state)
        ST_ZERO: begin
          w_we    = 1'b1;
          w_waddr = r_ptr;
          w_wdata = {DATA_W{1'b0}};
        end
        ST_LOAD: begin
          w_we    = load_valid;
          w_waddr = r_ptr;
          w_wdata = load_data;
        end
        ST_RUN: begin
          w_we    = write;
          w_waddr = address;
          w_wdata = memoryIn;
        end
        default: begin
          w_we = 1'b0;
        end
      endcase
    end
  end

  // Boot sequencer state, write pointer and sticky read/write conflict flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= ST_ZERO;
      r_ptr      <= {ADDR_W{1'b0}};
      r_conflict <= 1'b0;
    end else begin
      case (r_state)
        ST_ZERO: begin
          r_ptr <= r_ptr + ADDR_W'(1);
          if (r_ptr == LAST_ADDR) begin
            r_state <= ST_LOAD;
            r_ptr   <= {ADDR_W{1'b0}};
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            // Reaching the top word ends the load, so the pointer can never overflow.
            if (load_last || (r_ptr == LAST_ADDR)) begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (read && write) begin
            r_conflict <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_ZERO;
          r_ptr   <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  ram_sp_async_rd #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (address),
    .o_rdata (memoryOut)
  );

  assign load_ready = (r_state == ST_LOAD);
  assign cpu_clr    = (r_state != ST_RUN);
  assign conflict   = r_conflict;

endmodule

// File: tb/tb_cpu_memory_responder.sv
// Scoreboard bench: stimulus pushes expected observations, a negedge monitor pops and checks them.
module tb_cpu_memory_responder;

  localparam int K_MEM   = 0;
  localparam int K_READY = 1;
  localparam int K_CLR   = 2;
  localparam int K_CONF  = 3;

  typedef struct {
    int         kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr, read, write, load_valid, load_last;
  logic [3:0] address;
  logic [7:0] memoryIn, load_data;
  logic [7:0] memoryOut;
  logic       load_ready, cpu_clr, conflict;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cpu_memory_responder dut (
    .clk        (clk),
    .clr        (clr),
    .read       (read),
    .write      (write),
    .address    (address),
    .memoryIn   (memoryIn),
    .memoryOut  (memoryOut),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_clr    (cpu_clr),
    .conflict   (conflict)
  );

  // Monitor: all expectations queued this cycle are checked mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e = q.pop_front();
      case (e.kind)
        K_MEM:   act = memoryOut;
        K_READY: act = {7'd0, load_ready};
        K_CLR:   act = {7'd0, cpu_clr};
        default: act = {7'd0, conflict};
      endcase
      total = total + 1;
      if (act !== e.val) begin
        bad = bad + 1;
        $display("FAIL %s: actual=%h required=%h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(input int k, input logic [7:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input int a, input logic [7:0] v, input string n);
    address = 4'(a);
    expect_v(K_MEM, v, $sformatf("%s[%0d]", n, a));
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Spends the 16 ZERO cycles with CPU strobes active, checking ready/cpu_clr throughout.
  task automatic zero_pass(input string n);
    read = 1'b1; write = 1'b1; address = 4'd3; memoryIn = 8'h99;
    for (int i = 0; i < 16; i++) begin
      expect_v(K_READY, 8'd0, $sformatf("%s_ready_lo%0d", n, i));
      expect_v(K_CLR, 8'd1, $sformatf("%s_cpuclr%0d", n, i));
      tick();
    end
    read = 1'b0; write = 1'b0;
    expect_v(K_READY, 8'd1, {n, "_ready_hi"});
    expect_v(K_CONF, 8'd0, {n, "_no_conflict"});
  endtask

  initial begin
    clr = 1'b1; read = 1'b0; write = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    address = 4'd0; memoryIn = 8'h00; load_data = 8'h00;
    tick();
    clr = 1'b0;
    expect_v(K_CLR, 8'd1, "rst_cpuclr");
    expect_v(K_CONF, 8'd0, "rst_conflict");

    // 1: wipe pass, then all words read zero while waiting in LOAD
    zero_pass("t1");
    tick();
    for (int a = 0; a < 16; a++) chk_mem(a, 8'h00, "t1_zero");
    expect_v(K_CLR, 8'd1, "t1_cpuclr_hold");

    // 2: three-byte program; CPU write during LOAD must be ignored
    write = 1'b1; address = 4'd7; memoryIn = 8'hFF;
    load_valid = 1'b1; load_data = 8'hA0; tick();
    load_data = 8'hA1; tick();
    load_data = 8'hA2; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0; write = 1'b0;
    expect_v(K_CLR, 8'd0, "t2_cpuclr");
    expect_v(K_READY, 8'd0, "t2_ready");
    load_valid = 1'b1; load_data = 8'hEE; load_last = 1'b1;
    for (int a = 0; a < 16; a++)
      chk_mem(a, (a == 0) ? 8'hA0 : (a == 1) ? 8'hA1 : (a == 2) ? 8'hA2 : 8'h00, "t2_mem");
    load_valid = 1'b0; load_last = 1'b0;

    // 4: read-during-write returns old word, new word next cycle
    address = 4'd5; memoryIn = 8'h3C; write = 1'b1;
    expect_v(K_MEM, 8'h00, "t4_old");
    tick();
    write = 1'b0;
    expect_v(K_MEM, 8'h3C, "t4_new");
    tick();

    // 5: simultaneous read/write sets sticky conflict, write still lands
    address = 4'd2; memoryIn = 8'h77; read = 1'b1; write = 1'b1;
    expect_v(K_CONF, 8'd0, "t5_conf_before");
    expect_v(K_MEM, 8'hA2, "t5_old");
    tick();
    read = 1'b0; write = 1'b0;
    expect_v(K_CONF, 8'd1, "t5_conf_set");
    expect_v(K_MEM, 8'h77, "t5_new");
    tick();
    expect_v(K_CONF, 8'd1, "t5_conf_sticky");
    tick();
    do_clr();
    expect_v(K_CONF, 8'd0, "t5_conf_clr");
    expect_v(K_CLR, 8'd1, "t5_cpuclr");

    // 3: full 16-byte load without last; a 17th byte is dropped
    zero_pass("t3");
    load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_data = 8'h10 + 8'(i);
      tick();
    end
    load_data = 8'hEE;
    expect_v(K_CLR, 8'd0, "t3_cpuclr");
    expect_v(K_READY, 8'd0, "t3_ready");
    tick();
    load_valid = 1'b0;
    for (int a = 0; a < 16; a++) chk_mem(a, 8'h10 + 8'(a), "t3_mem");

    // 6: clr mid-load restarts the wipe; then a one-byte program
    do_clr();
    zero_pass("t6a");
    write = 1'b1; address = 4'd4; memoryIn = 8'h66;
    load_valid = 1'b1; load_data = 8'hAA; tick();
    load_data = 8'hBB; tick();
    clr = 1'b1; load_data = 8'hCC; tick();
    clr = 1'b0; load_valid = 1'b0; write = 1'b0;
    zero_pass("t6b");
    for (int a = 0; a < 16; a++) chk_mem(a, 8'h00, "t6_rezero");
    load_valid = 1'b1; load_data = 8'h55; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    expect_v(K_CLR, 8'd0, "t6_cpuclr");
    chk_mem(0, 8'h55, "t6_mem");
    chk_mem(1, 8'h00, "t6_mem");
    chk_mem(4, 8'h00, "t6_mem");

    for (int w = 0; w < 10 && q.size() > 0; w++) tick();
    if (q.size() > 0) begin
      bad = bad + 1;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
